// File: rtl/dcache_pkg.sv
// Shared types and geometry for the direct-mapped write-back data cache.
// Index/tag widths are derived from the set count so the array and controller agree.
package dcache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        FILL,
        RESPOND
    } state_e;

    localparam int LINE_BITS   = 512;
    localparam int WORD_BITS   = 64;
    localparam int OFFSET_BITS = 6;
    localparam int ADDR_BITS   = 64;

    function automatic int index_bits(input int num_sets);
        return $clog2(num_sets);
    endfunction

    function automatic int tag_bits(input int num_sets);
        return ADDR_BITS - OFFSET_BITS - $clog2(num_sets);
    endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag/valid/dirty/data storage: combinational read by index, synchronous line fill,
// word merge and dirty-clear writes. Only valid/dirty are reset.
module data_cache_array
    import dcache_pkg::*;
#(
    parameter  int NUM_SETS = 64,
    localparam int IDX_W    = index_bits(NUM_SETS),
    localparam int TAG_W    = tag_bits(NUM_SETS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [IDX_W-1:0]     index_i,
    output logic [TAG_W-1:0]     rd_tag_o,
    output logic                 rd_valid_o,
    output logic                 rd_dirty_o,
    output logic [LINE_BITS-1:0] rd_line_o,
    input  logic                 line_we_i,
    input  logic [TAG_W-1:0]     line_tag_i,
    input  logic [LINE_BITS-1:0] line_data_i,
    input  logic                 line_dirty_i,
    input  logic                 word_we_i,
    input  logic [2:0]           word_sel_i,
    input  logic [WORD_BITS-1:0] word_data_i,
    input  logic                 clean_i
);

    logic [NUM_SETS-1:0]  valid_q;
    logic [NUM_SETS-1:0]  dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_SETS];
    logic [LINE_BITS-1:0] data_q [NUM_SETS];

    assign rd_tag_o   = tag_q[index_i];
    assign rd_valid_o = valid_q[index_i];
    assign rd_dirty_o = dirty_q[index_i];
    assign rd_line_o  = data_q[index_i];

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (line_we_i) begin
            valid_q[index_i] <= 1'b1;
            dirty_q[index_i] <= line_dirty_i;
        end else if (word_we_i) begin
            dirty_q[index_i] <= 1'b1;
        end else if (clean_i) begin
            dirty_q[index_i] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (line_we_i) begin
            tag_q[index_i]  <= line_tag_i;
            data_q[index_i] <= line_data_i;
        end else if (word_we_i) begin
            data_q[index_i][{word_sel_i, 6'b0} +: WORD_BITS] <= word_data_i;
        end
    end

endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back, write-allocate L1 data cache: controller FSM plus
// request/response muxing around data_cache_array.
module data_cache
    import dcache_pkg::*;
#(
    parameter int NUM_SETS   = 64,
    parameter int LINE_BYTES = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 wenable,
    input  logic [63:0]          addr,
    input  logic [63:0]          wdata,
    output logic [63:0]          rdata,
    output logic                 done,
    output logic                 mem_req,
    output logic                 mem_wren,
    output logic [63:0]          mem_addr,
    input  logic [LINE_BITS-1:0] mem_rdata,
    output logic [LINE_BITS-1:0] mem_wdata,
    input  logic                 mem_done
);

    localparam int IDX_W      = index_bits(NUM_SETS);
    localparam int TAG_W      = tag_bits(NUM_SETS);
    localparam int WORD_SEL_W = $clog2(LINE_BYTES * 8 / WORD_BITS);

    state_e               state_q, state_d;
    logic [63:0]          rdata_q, rdata_d;
    logic                 done_q, done_d;
    logic                 mem_req_q, mem_req_d;
    logic                 mem_wren_q, mem_wren_d;
    logic [63:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_wdata_q, mem_wdata_d;

    logic [IDX_W-1:0]      index;
    logic [TAG_W-1:0]      tag;
    logic [WORD_SEL_W-1:0] wsel;
    logic [TAG_W-1:0]      rd_tag;
    logic                  rd_valid, rd_dirty, hit;
    logic [LINE_BITS-1:0]  rd_line, fill_line;
    logic [63:0]           line_word, fill_word, line_addr;
    logic                  line_we, word_we, clean;
    logic                  unused_addr_bits;

    assign index            = addr[OFFSET_BITS +: IDX_W];
    assign tag              = addr[63 -: TAG_W];
    assign wsel             = addr[OFFSET_BITS-1 -: WORD_SEL_W];
    assign line_addr        = {addr[63:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
    assign hit              = rd_valid && (rd_tag == tag);
    assign line_word        = rd_line[{wsel, 6'b0} +: WORD_BITS];
    assign fill_word        = mem_rdata[{wsel, 6'b0} +: WORD_BITS];
    assign unused_addr_bits = ^addr[2:0];

    // A store miss allocates the fetched line with the store already merged in.
    always_comb begin
        fill_line = mem_rdata;
        if (wenable) begin
            fill_line[{wsel, 6'b0} +: WORD_BITS] = wdata;
        end
    end

    data_cache_array #(.NUM_SETS(NUM_SETS)) u_array (
        .clk          (clk),
        .reset        (reset),
        .index_i      (index),
        .rd_tag_o     (rd_tag),
        .rd_valid_o   (rd_valid),
        .rd_dirty_o   (rd_dirty),
        .rd_line_o    (rd_line),
        .line_we_i    (line_we),
        .line_tag_i   (tag),
        .line_data_i  (fill_line),
        .line_dirty_i (wenable),
        .word_we_i    (word_we),
        .word_sel_i   (wsel),
        .word_data_i  (wdata),
        .clean_i      (clean)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            rdata_q     <= '0;
            done_q      <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_wren_q  <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            rdata_q     <= rdata_d;
            done_q      <= done_d;
            mem_req_q   <= mem_req_d;
            mem_wren_q  <= mem_wren_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rdata_d     = rdata_q;
        done_d      = 1'b0;
        mem_req_d   = mem_req_q;
        mem_wren_d  = mem_wren_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        line_we     = 1'b0;
        word_we     = 1'b0;
        clean       = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    if (hit) begin
                        done_d  = 1'b1;
                        state_d = RESPOND;
                        if (wenable) begin
                            word_we = 1'b1;
                        end else begin
                            rdata_d = line_word;
                        end
                    end else if (rd_valid && rd_dirty) begin
                        mem_req_d   = 1'b1;
                        mem_wren_d  = 1'b1;
                        mem_addr_d  = {rd_tag, index, {OFFSET_BITS{1'b0}}};
                        mem_wdata_d = rd_line;
                        state_d     = WRITEBACK;
                    end else begin
                        mem_req_d  = 1'b1;
                        mem_wren_d = 1'b0;
                        mem_addr_d = line_addr;
                        state_d    = FILL;
                    end
                end
            end
            WRITEBACK: begin
                // mem_req stays high so the fill follows the writeback without a gap.
                if (mem_done) begin
                    clean      = 1'b1;
                    mem_wren_d = 1'b0;
                    mem_addr_d = line_addr;
                    state_d    = FILL;
                end
            end
            FILL: begin
                if (mem_done) begin
                    line_we   = 1'b1;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = RESPOND;
                    if (!wenable) begin
                        rdata_d = fill_word;
                    end
                end
            end
            RESPOND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rdata     = rdata_q;
    assign done      = done_q;
    assign mem_req   = mem_req_q;
    assign mem_wren  = mem_wren_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_data_cache.sv
// Scenario bench for data_cache: arbiter model with backing memory, architectural
// memory model and scoreboards for load data and arbiter transactions.
module tb_data_cache;

    localparam int ARB_LAT = 5;

    logic         clk = 1'b0;
    logic         reset, enable, wenable;
    logic [63:0]  addr, wdata, rdata, mem_addr;
    logic         done, mem_req, mem_wren, mem_done;
    logic [511:0] mem_rdata, mem_wdata;

    always #5 clk = ~clk;

    data_cache #(.NUM_SETS(64), .LINE_BYTES(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .wenable   (wenable),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .done      (done),
        .mem_req   (mem_req),
        .mem_wren  (mem_wren),
        .mem_addr  (mem_addr),
        .mem_rdata (mem_rdata),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done)
    );

    typedef struct {
        logic        is_load;
        logic [63:0] data;
    } exp_t;

    typedef struct {
        logic         wren;
        logic [63:0]  addr;
        logic [511:0] wdata;
    } txn_t;

    exp_t        exp_q[$];
    txn_t        exp_txn_q[$];
    txn_t        obs_txn_q[$];
    logic [63:0] back_mem [logic [63:0]];
    logic [63:0] arch_mem [logic [63:0]];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int mem_done_cyc = -100;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] pat(input logic [63:0] a);
        return {a[31:0] ^ 32'h5A5A_0000, ~a[31:0]};
    endfunction

    function automatic logic [63:0] back_get(input logic [63:0] a);
        return back_mem.exists(a) ? back_mem[a] : pat(a);
    endfunction

    function automatic logic [63:0] arch_get(input logic [63:0] a);
        return arch_mem.exists(a) ? arch_mem[a] : pat(a);
    endfunction

    function automatic logic [511:0] arch_line(input logic [63:0] la);
        logic [511:0] l;
        for (int i = 0; i < 8; i++) l[i*64 +: 64] = arch_get(la + 64'(i * 8));
        return l;
    endfunction

    function automatic txn_t pop_obs();
        txn_t t;
        t.wren = 1'bx; t.addr = 'x; t.wdata = 'x;
        if (obs_txn_q.size() > 0) t = obs_txn_q.pop_front();
        return t;
    endfunction

    function automatic txn_t pop_exp_txn();
        txn_t t;
        t.wren = 1'bx; t.addr = 'x; t.wdata = 'x;
        if (exp_txn_q.size() > 0) t = exp_txn_q.pop_front();
        return t;
    endfunction

    function automatic void push_txn(input logic w, input logic [63:0] a, input logic [511:0] d);
        txn_t t;
        t.wren = w; t.addr = a; t.wdata = d;
        exp_txn_q.push_back(t);
    endfunction

    // Arbiter: logs each request, answers after ARB_LAT cycles, aborts on reset.
    initial begin
        txn_t t;
        bit   aborted;
        mem_done  = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_done = 1'b0;
            if (mem_req === 1'b1 && reset === 1'b0) begin
                t.wren = mem_wren; t.addr = mem_addr; t.wdata = mem_wdata;
                obs_txn_q.push_back(t);
                aborted = 1'b0;
                repeat (ARB_LAT) begin
                    @(negedge clk);
                    if (reset === 1'b1) aborted = 1'b1;
                end
                if (!aborted) begin
                    for (int i = 0; i < 8; i++) begin
                        if (t.wren) back_mem[t.addr + 64'(i * 8)] = t.wdata[i*64 +: 64];
                        else        mem_rdata[i*64 +: 64] = back_get(t.addr + 64'(i * 8));
                    end
                    mem_done     = 1'b1;
                    mem_done_cyc = cyc;
                end
            end
        end
    end

    // Drives one access from a negedge, waits (bounded) for done and reports timing.
    task automatic do_access(input logic wen, input logic [63:0] a, input logic [63:0] wd,
                             output int lat, output logic [63:0] rd, output logic dn,
                             output int dcyc);
        exp_t e;
        int   n;
        e.is_load = !wen;
        e.data    = wen ? 64'h0 : arch_get(a);
        if (wen) arch_mem[a] = wd;
        exp_q.push_back(e);
        enable = 1'b1; wenable = wen; addr = a; wdata = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 200);
        lat    = n;
        rd     = rdata;
        dcyc   = cyc;
        enable = 1'b0;
        @(negedge clk);
        dn = done;
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; wenable = 1'b0; addr = '0; wdata = '0;
        repeat (3) @(negedge clk);
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b want=0", done); end
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got=%b want=0", mem_req); end
        vectors++; if (mem_wren !== 1'b0) begin miscompares++; $display("FAIL reset_mem_wren got=%b want=0", mem_wren); end
        vectors++; if (rdata !== 64'h0) begin miscompares++; $display("FAIL reset_rdata got=%h want=0", rdata); end
        vectors++; if (mem_addr !== 64'h0) begin miscompares++; $display("FAIL reset_mem_addr got=%h want=0", mem_addr); end
        vectors++; if (mem_wdata !== 512'h0) begin miscompares++; $display("FAIL reset_mem_wdata got=%h want=0", mem_wdata); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_load();
        int lat, dcyc; logic [63:0] rd; logic dn; exp_t e; txn_t o, x;
        push_txn(1'b0, 64'h1000, '0);
        do_access(1'b0, 64'h1008, 64'h0, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (rd !== e.data) begin miscompares++; $display("FAIL cold_rdata got=%h want=%h", rd, e.data); end
        vectors++; if (obs_txn_q.size() != 1) begin miscompares++; $display("FAIL cold_txn_count got=%0d want=1", obs_txn_q.size()); end
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr) begin miscompares++; $display("FAIL cold_txn got=%b/%h want=%b/%h", o.wren, o.addr, x.wren, x.addr); end
        vectors++; if (dcyc != mem_done_cyc + 1) begin miscompares++; $display("FAIL cold_done_timing got=%0d want=%0d", dcyc, mem_done_cyc + 1); end
        vectors++; if (lat != ARB_LAT + 2) begin miscompares++; $display("FAIL cold_latency got=%0d want=%0d", lat, ARB_LAT + 2); end
        vectors++; if (dn !== 1'b0) begin miscompares++; $display("FAIL cold_done_pulse got=%b want=0", dn); end
    endtask

    task automatic test_hits();
        int lat, dcyc; logic [63:0] rd; logic dn; exp_t e;
        do_access(1'b0, 64'h1008, 64'h0, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (rd !== e.data) begin miscompares++; $display("FAIL hit_rdata got=%h want=%h", rd, e.data); end
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL hit_latency got=%0d want=1", lat); end
        do_access(1'b1, 64'h1010, 64'h1234, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL store_hit_latency got=%0d want=1", lat); end
        do_access(1'b0, 64'h1010, 64'h0, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (rd !== e.data) begin miscompares++; $display("FAIL store_load_rdata got=%h want=%h", rd, e.data); end
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL store_load_latency got=%0d want=1", lat); end
        vectors++; if (obs_txn_q.size() != 0) begin miscompares++; $display("FAIL hit_traffic got=%0d want=0", obs_txn_q.size()); end
    endtask

    task automatic test_conflict();
        int lat, dcyc; logic [63:0] rd; logic dn; exp_t e; txn_t o, x;
        push_txn(1'b1, 64'h1000, arch_line(64'h1000));
        push_txn(1'b0, 64'h2000, '0);
        do_access(1'b0, 64'h2010, 64'h0, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (obs_txn_q.size() != 2) begin miscompares++; $display("FAIL conflict_txn_count got=%0d want=2", obs_txn_q.size()); end
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr) begin miscompares++; $display("FAIL conflict_wb got=%b/%h want=%b/%h", o.wren, o.addr, x.wren, x.addr); end
        vectors++; if (o.wdata !== x.wdata) begin miscompares++; $display("FAIL conflict_wb_data got=%h want=%h", o.wdata, x.wdata); end
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr) begin miscompares++; $display("FAIL conflict_fill got=%b/%h want=%b/%h", o.wren, o.addr, x.wren, x.addr); end
        vectors++; if (rd !== e.data) begin miscompares++; $display("FAIL conflict_rdata got=%h want=%h", rd, e.data); end
        vectors++; if (lat != 2 * ARB_LAT + 3) begin miscompares++; $display("FAIL conflict_latency got=%0d want=%0d", lat, 2 * ARB_LAT + 3); end
    endtask

    task automatic test_store_miss();
        int lat, dcyc; logic [63:0] rd; logic dn; exp_t e; txn_t o, x;
        push_txn(1'b0, 64'h3000, '0);
        do_access(1'b1, 64'h3000, 64'h0BAD_CAFE_0000_5A01, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (obs_txn_q.size() != 1) begin miscompares++; $display("FAIL smiss_txn_count got=%0d want=1", obs_txn_q.size()); end
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr) begin miscompares++; $display("FAIL smiss_fill got=%b/%h want=%b/%h", o.wren, o.addr, x.wren, x.addr); end
        vectors++; if (lat != ARB_LAT + 2) begin miscompares++; $display("FAIL smiss_latency got=%0d want=%0d", lat, ARB_LAT + 2); end
        push_txn(1'b1, 64'h3000, arch_line(64'h3000));
        push_txn(1'b0, 64'h1000, '0);
        do_access(1'b0, 64'h1008, 64'h0, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (obs_txn_q.size() != 2) begin miscompares++; $display("FAIL evict_txn_count got=%0d want=2", obs_txn_q.size()); end
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr || o.wdata !== x.wdata) begin miscompares++; $display("FAIL evict_wb got=%b/%h/%h want=%b/%h/%h", o.wren, o.addr, o.wdata[63:0], x.wren, x.addr, x.wdata[63:0]); end
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr) begin miscompares++; $display("FAIL evict_fill got=%b/%h want=%b/%h", o.wren, o.addr, x.wren, x.addr); end
        vectors++; if (rd !== e.data) begin miscompares++; $display("FAIL evict_rdata got=%h want=%h", rd, e.data); end
    endtask

    task automatic test_reset_fill();
        int lat, dcyc; logic [63:0] rd; logic dn; exp_t e; txn_t o, x;
        push_txn(1'b0, 64'h5000, '0);
        enable = 1'b1; wenable = 1'b0; addr = 64'h5008; wdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL rstfill_mem_req got=%b want=0", mem_req); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL rstfill_done got=%b want=0", done); end
        @(negedge clk);
        reset = 1'b0; enable = 1'b0;
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr) begin miscompares++; $display("FAIL rstfill_txn got=%b/%h want=%b/%h", o.wren, o.addr, x.wren, x.addr); end
        push_txn(1'b0, 64'h1000, '0);
        do_access(1'b0, 64'h1008, 64'h0, lat, rd, dn, dcyc);
        e = exp_q.pop_front();
        vectors++; if (obs_txn_q.size() != 1) begin miscompares++; $display("FAIL rstfill_reload_count got=%0d want=1", obs_txn_q.size()); end
        o = pop_obs(); x = pop_exp_txn();
        vectors++; if (o.wren !== x.wren || o.addr !== x.addr) begin miscompares++; $display("FAIL rstfill_reload got=%b/%h want=%b/%h", o.wren, o.addr, x.wren, x.addr); end
        vectors++; if (rd !== e.data) begin miscompares++; $display("FAIL rstfill_rdata got=%h want=%h", rd, e.data); end
    endtask

    task automatic test_back_to_back();
        int lat, dcyc, n; logic [63:0] rd; logic dn; exp_t e;
        for (int i = 0; i < 8; i++) begin
            do_access(1'b1, 64'h1000 + 64'(i * 8), {$urandom, $urandom}, lat, rd, dn, dcyc);
            e = exp_q.pop_front();
            vectors++; if (lat != 1) begin miscompares++; $display("FAIL b2b_store_latency idx=%0d got=%0d want=1", i, lat); end
        end
        for (int i = 0; i < 8; i++) begin
            e.is_load = 1'b1; e.data = arch_get(64'h1000 + 64'(i * 8));
            exp_q.push_back(e);
        end
        enable = 1'b1; wenable = 1'b0; addr = 64'h1000;
        for (int i = 0; i < 8; i++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (done !== 1'b1 && n < 20);
            e = exp_q.pop_front();
            vectors++; if (rdata !== e.data) begin miscompares++; $display("FAIL b2b_rdata idx=%0d got=%h want=%h", i, rdata, e.data); end
            vectors++; if (n != ((i == 0) ? 1 : 2)) begin miscompares++; $display("FAIL b2b_spacing idx=%0d got=%0d want=%0d", i, n, (i == 0) ? 1 : 2); end
            if (i < 7) addr = 64'h1000 + 64'((i + 1) * 8);
            else       enable = 1'b0;
        end
        @(negedge clk);
        vectors++; if (obs_txn_q.size() != 0) begin miscompares++; $display("FAIL b2b_traffic got=%0d want=0", obs_txn_q.size()); end
    endtask

    initial begin
        back_mem[64'h1008] = 64'hDEADBEEF_00000001;
        arch_mem[64'h1008] = 64'hDEADBEEF_00000001;
        test_reset();
        test_cold_load();
        test_hits();
        test_conflict();
        test_store_miss();
        test_reset_fill();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
